// File: rtl/debug_capture_pkg.sv
// Shared definitions for the debug capture buffer: debug word width and FSM state encoding.
package debug_capture_pkg;

  localparam int DEBUG_WIDTH = 53;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/debug_capture_ram.sv
// Simple dual-port capture RAM: one write port, one registered read port, no reset so it maps to block RAM.
module debug_capture_ram
  import debug_capture_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                   clk_i,
  input  logic                   wr_en,
  input  logic [DEPTH_LOG2-1:0]  wr_addr,
  input  logic [DEBUG_WIDTH-1:0] wr_data,
  input  logic                   rd_en,
  input  logic [DEPTH_LOG2-1:0]  rd_addr,
  output logic [DEBUG_WIDTH-1:0] rd_data
);

  logic [DEBUG_WIDTH-1:0] mem [2**DEPTH_LOG2];

  always_ff @(posedge clk_i) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk_i) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/debug_capture_buffer.sv
// Trigger-window capture of the debug bus into block RAM with word-by-word host readout.
module debug_capture_buffer
  import debug_capture_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int PRE_TRIG   = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic [DEBUG_WIDTH-1:0] debug_i,
  input  logic                   arm_i,
  input  logic                   force_trig_i,
  input  logic [DEBUG_WIDTH-1:0] trig_mask_i,
  input  logic [DEBUG_WIDTH-1:0] trig_value_i,
  input  logic                   rd_i,
  output logic [DEBUG_WIDTH-1:0] rd_data_o,
  output logic                   rd_valid_o,
  output logic                   done_o,
  output logic [2:0]             state_o,
  output logic [DEPTH_LOG2-1:0]  trig_addr_o
);

  localparam int DEPTH  = 2**DEPTH_LOG2;
  localparam int POST_N = DEPTH - PRE_TRIG - 1;

  localparam logic [DEPTH_LOG2-1:0] PRE_W     = DEPTH_LOG2'(PRE_TRIG);
  localparam logic [DEPTH_LOG2-1:0] PRE_LAST  = DEPTH_LOG2'(PRE_TRIG - 1);
  localparam logic [DEPTH_LOG2-1:0] POST_LAST = DEPTH_LOG2'(POST_N - 1);
  localparam logic [DEPTH_LOG2:0]   RD_LAST   = (DEPTH_LOG2+1)'(DEPTH - 1);

  state_t                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, samp_cnt_q, trig_addr_q, rd_addr_p0;
  logic [DEPTH_LOG2:0]     rd_cnt_q;
  logic                    trig_hit, wr_en, rd_acc_p0, vld_p1;
  logic [DEBUG_WIDTH-1:0]  ram_q_p1;

  assign trig_hit = (((debug_i ^ trig_value_i) & trig_mask_i) == '0) || force_trig_i;

  // Read address walks the window from its oldest sample, wrapping modulo depth.
  assign rd_addr_p0 = trig_addr_q - PRE_W + rd_cnt_q[DEPTH_LOG2-1:0];

  always_comb begin
    state_d   = state_q;
    wr_en     = 1'b0;
    rd_acc_p0 = 1'b0;
    if (arm_i) begin
      state_d = (PRE_TRIG == 0) ? ST_WAIT : ST_FILL;
    end else begin
      case (state_q)
        ST_FILL: begin
          wr_en = 1'b1;
          if (samp_cnt_q == PRE_LAST) state_d = ST_WAIT;
        end
        ST_WAIT: begin
          wr_en = 1'b1;
          if (trig_hit) state_d = (POST_N == 0) ? ST_DONE : ST_POST;
        end
        ST_POST: begin
          wr_en = 1'b1;
          if (samp_cnt_q == POST_LAST) state_d = ST_DONE;
        end
        ST_DONE: begin
          if (rd_i) begin
            rd_acc_p0 = 1'b1;
            if (rd_cnt_q == RD_LAST) state_d = ST_IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      samp_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      trig_addr_q <= '0;
      vld_p1      <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_p1  <= rd_acc_p0;
      if (arm_i) begin
        wr_ptr_q   <= '0;
        samp_cnt_q <= '0;
        rd_cnt_q   <= '0;
      end else begin
        if (wr_en)     wr_ptr_q <= wr_ptr_q + 1'b1;
        if (rd_acc_p0) rd_cnt_q <= rd_cnt_q + 1'b1;
        case (state_q)
          ST_FILL: samp_cnt_q <= (samp_cnt_q == PRE_LAST) ? '0 : samp_cnt_q + 1'b1;
          ST_WAIT: if (trig_hit) trig_addr_q <= wr_ptr_q;
          ST_POST: samp_cnt_q <= samp_cnt_q + 1'b1;
          default: ;
        endcase
      end
    end
  end

  debug_capture_ram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_ram (
    .clk_i   (clk_i),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data (debug_i),
    .rd_en   (rd_acc_p0),
    .rd_addr (rd_addr_p0),
    .rd_data (ram_q_p1)
  );

  // p1 -> p2: output register holds the last word between reads.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_valid_o <= 1'b0;
      rd_data_o  <= '0;
    end else begin
      rd_valid_o <= vld_p1;
      if (vld_p1) rd_data_o <= ram_q_p1;
    end
  end

  assign done_o      = (state_q == ST_DONE);
  assign state_o     = state_q;
  assign trig_addr_o = trig_addr_q;

endmodule

// File: doc/debug_capture_buffer.md
# debug_capture_buffer

In-fabric capture buffer for the 53-bit debug buses: it records a window of samples around a trigger condition into block RAM, then plays them back word by word to a host-side reader. It is the readout end of the debug path. The ChipScope ILAs only capture over JTAG; this block makes the same debug words readable over the normal register/readout path, in builds with or without ChipScope cores. One instance sits beside the debug wrapper, on the same clock as the debug bus it samples.

## Interface
Parameters:
- DEPTH_LOG2, 8: buffer depth is 2^DEPTH_LOG2 words (256).
- PRE_TRIG, 64: samples kept before the trigger sample; legal range 0 to 2^DEPTH_LOG2-1.

Ports:
- clk_i  in  1  capture and readout clock; one clock, no CDC inside.
- rst_n_i  in  1  reset, asynchronous and active-low.
- debug_i  in  53  debug word, sampled every clk_i cycle.
- arm_i  in  1  single-cycle pulse; starts a new capture from any state.
- force_trig_i  in  1  unconditional trigger, honoured only in WAIT.
- trig_mask_i  in  53  trigger compare mask; a 1 means the bit is compared.
- trig_value_i  in  53  trigger compare value.
- rd_i  in  1  read strobe, one word per asserted cycle.
- rd_data_o  out  53  readout word.
- rd_valid_o  out  1  rd_data_o is valid this cycle.
- done_o  out  1  capture complete; readout available.
- state_o  out  3  current state encoding.
- trig_addr_o  out  DEPTH_LOG2  RAM address of the trigger sample.

## Operation
- States: IDLE=0, FILL=1, WAIT=2, POST=3, DONE=4.
- IDLE: no RAM writes. rd_i is ignored.
- arm_i, in any state:
  - write pointer, sample counter and read counter go to 0;
  - next state is FILL, or WAIT when PRE_TRIG=0.
  - A capture or readout in progress is aborted.
- FILL:
  - debug_i is written at the write pointer every cycle and the pointer increments.
  - After PRE_TRIG writes, go to WAIT.
  - Trigger matches are ignored.
- WAIT:
  - Writes continue every cycle; the pointer wraps modulo 2^DEPTH_LOG2.
  - Trigger condition: ((debug_i ^ trig_value_i) & trig_mask_i) == 0, or force_trig_i.
  - Evaluated combinationally on the same-cycle debug_i; that sample is the trigger sample.
  - On trigger: trig_addr_o is loaded with the current write pointer, the trigger sample is written, then go to POST, or to DONE if 2^DEPTH_LOG2-PRE_TRIG-1 = 0.
  - A mask of all zeros triggers on the first WAIT cycle.
- POST: write exactly 2^DEPTH_LOG2-PRE_TRIG-1 further samples, then go to DONE.
- Captured window:
  - 2^DEPTH_LOG2 contiguous samples.
  - The oldest is at trig_addr_o-PRE_TRIG, modulo depth.
  - Post-trigger writes end at trig_addr_o-PRE_TRIG-1, so no pre-trigger sample is overwritten.
- DONE:
  - done_o=1 and no writes.
  - The read pointer starts at trig_addr_o-PRE_TRIG.
  - Each rd_i reads one word and increments the read pointer (wraps) and the read counter.
  - After 2^DEPTH_LOG2 accepted reads, go to IDLE and done_o drops.
  - rd_i in any state other than DONE is ignored; no rd_valid_o is produced.
- Priority: arm_i beats trigger and beats rd_i in the same cycle. A simultaneous rd_i produces no rd_valid_o.
- Width rules: all pointer and counter arithmetic is unsigned and modulo 2^DEPTH_LOG2. The read counter is DEPTH_LOG2+1 bits so it can count to the full depth.

## Timing
- Reset values: state_o=IDLE, done_o=0, rd_valid_o=0, rd_data_o=0, trig_addr_o=0, all pointers and counters 0. RAM contents are undefined.
- Arm: arm_i high at edge N gives state_o=FILL after edge N. The first sample written is debug_i at edge N+1.
- Trigger: trigger condition true at edge T gives state_o=POST after T. done_o rises after edge T+(2^DEPTH_LOG2-PRE_TRIG-1).
- Read latency: rd_i at edge N gives rd_valid_o=1 and valid rd_data_o after edge N+1 (synchronous RAM read).
  - Back-to-back rd_i gives one word per cycle.
  - rd_data_o holds its last value when rd_valid_o=0.
- Reset asserted mid-capture or mid-readout: immediate return to IDLE. The RAM is not cleared.

## Structure
- Package debug_capture_pkg:
  - DEBUG_WIDTH=53;
  - state encoding constants ST_IDLE, ST_FILL, ST_WAIT, ST_POST, ST_DONE.
- Sub-module debug_capture_ram: simple dual-port RAM, DEBUG_WIDTH x 2^DEPTH_LOG2, one write port, registered read port, no reset. It must infer block RAM.
- The top level holds the FSM, the trigger comparator, the pointers and the counters.

## Test plan
- Pre/post window: reset, PRE_TRIG=64, debug_i = a free-running counter, arm, trig_mask=all ones, trig_value=500 -> done_o rises 191 cycles after the trigger; 256 reads return 436..691 consecutively; rd_valid_o falls and state_o=IDLE after the last read.
- Trigger during FILL: debug_i matches on cycles 1–10 after arm with PRE_TRIG=64 -> no trigger; the first match in WAIT is taken; read word 64 equals the trigger value.
- force_trig_i: pulse 3 cycles into WAIT with mask unmatched -> trigger taken; trig_addr_o equals the write pointer at that cycle.
- Re-arm mid-capture: arm_i in POST, and again in DONE after 10 reads -> both abort; the new capture is clean; no rd_valid_o on the arm cycle when rd_i is also high.
- Boundaries: PRE_TRIG=0 (arm goes straight to WAIT; first read is the trigger word) and PRE_TRIG=255 (trigger goes straight to DONE; last read is the trigger word).
- Reset mid-readout and idle reads: rst_n_i low after 100 reads -> all outputs return to their reset values asynchronously; rd_i in IDLE gives no rd_valid_o.
